// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
//   Bundles the three handshakes around the cache/memory arbiter:
//     I-cache : i_read, i_addr            -> i_rdata, i_resp
//     D-cache : d_read, d_write, d_addr,
//               d_wdata                   -> d_rdata, d_resp
//     pmem    : pmem_read, pmem_write,
//               pmem_addr, pmem_wdata     <- pmem_rdata, pmem_resp
//   modport slave  : the arbiter (answers the caches, drives pmem)
//   modport master : the environment (caches plus physical memory)
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//   Arbitrates the I-cache line-read port and the D-cache line read/write port
//   onto one burst-based physical memory port. A line of LINE_W bits moves as
//   LINE_W/BEAT_W beats. Each finished transfer is answered with a one-cycle
//   i_resp/d_resp pulse, which the pipeline stall logic consumes.
//
//   Ports
//     clk  : clock
//     rst  : asynchronous, active-high reset
//     bus  : cache_mem_arbiter_if.slave (cache requests in, pmem burst out)
//
//   Arbitration: a lone requester is granted directly; when both caches are
//   waiting the side that was not granted last wins. last_grant resets to I,
//   so the first contention after reset goes to D. A request with both d_read
//   and d_write set is served as a writeback.
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input logic                 clk,
    input logic                 rst,
    cache_mem_arbiter_if.slave  bus
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((LINE_W / 8) - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] I_RD = 3'd1;
    localparam logic [2:0] D_RD = 3'd2;
    localparam logic [2:0] D_WR = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line_buf;    // read fill buffer, or latched writeback line
    logic [ADDR_W-1:0] addr_q;      // line-aligned address of the current burst
    logic              grant_d_q;   // current transfer belongs to the D-cache
    logic              wr_q;        // current transfer is a writeback
    logic              last_d_q;    // most recent grant went to the D-cache

    logic              i_req;
    logic              d_req;
    logic              grant_d;
    logic [ADDR_W-1:0] req_addr;

    assign i_req    = bus.i_read;
    assign d_req    = bus.d_read | bus.d_write;
    // D wins when alone, or on contention when I was served last.
    assign grant_d  = d_req & (~i_req | ~last_d_q);
    assign req_addr = grant_d ? bus.d_addr : bus.i_addr;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            // NOTE: line_buf is a flop bank, not RAM, so it takes the reset
            // like any other register; rdata must read 0 straight after reset.
            line_buf  <= '0;
            addr_q    <= '0;
            grant_d_q <= 1'b0;
            wr_q      <= 1'b0;
            last_d_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        addr_q    <= req_addr & LINE_MASK;
                        grant_d_q <= grant_d;
                        wr_q      <= grant_d & bus.d_write;
                        last_d_q  <= grant_d;
                        cnt       <= '0;
                        if (grant_d && bus.d_write) begin
                            line_buf <= bus.d_wdata;
                            state    <= D_WR;
                        end else if (grant_d) begin
                            state    <= D_RD;
                        end else begin
                            state    <= I_RD;
                        end
                    end
                end

                I_RD, D_RD: begin
                    if (bus.pmem_resp) begin
                        line_buf[int'(cnt)*BEAT_W +: BEAT_W] <= bus.pmem_rdata;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end
                end

                D_WR: begin
                    if (bus.pmem_resp) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end
                end

                // One-cycle bubble: a request still held high while the
                // response pulses is not re-sampled until the next IDLE.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only, so an asynchronous reset
    // silences every output immediately.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_addr  = '0;
        bus.pmem_wdata = '0;
        bus.i_resp     = 1'b0;
        bus.i_rdata    = '0;
        bus.d_resp     = 1'b0;
        bus.d_rdata    = '0;
        case (state)
            I_RD, D_RD: begin
                bus.pmem_read = 1'b1;
                bus.pmem_addr = addr_q;
            end
            D_WR: begin
                bus.pmem_write = 1'b1;
                bus.pmem_addr  = addr_q;
                bus.pmem_wdata = line_buf[int'(cnt)*BEAT_W +: BEAT_W];
            end
            DONE: begin
                if (grant_d_q) begin
                    bus.d_resp = 1'b1;
                    if (!wr_q) begin
                        bus.d_rdata = line_buf;
                    end
                end else begin
                    bus.i_resp  = 1'b1;
                    bus.i_rdata = line_buf;
                end
            end
            default: ;
        endcase
    end
endmodule
